// File: rtl/shiftreg_deser_if.sv
// Serial-in / parallel-out bus for shiftreg_deser.
// The slave modport is the deserializer side; the master modport is the producer/consumer side.
interface shiftreg_deser_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             i_bit;
  logic             i_bit_valid;
  logic             o_bit_ready;
  logic             i_clear;
  logic [WIDTH-1:0] o_word;
  logic             o_valid;
  logic             i_ready;
  logic [CW-1:0]    o_count;

  modport master (
    output i_bit, i_bit_valid, i_clear, i_ready,
    input  o_bit_ready, o_word, o_valid, o_count
  );

  modport slave (
    input  i_bit, i_bit_valid, i_clear, i_ready,
    output o_bit_ready, o_word, o_valid, o_count
  );
endinterface

// File: rtl/shiftreg_deser.sv
// MSB-first serial-to-parallel deserializer with a one-word output register.
// A completed word waits in the shift stage (FULL) only while the output register is occupied.
module shiftreg_deser #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  shiftreg_deser_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {ST_COLLECT, ST_FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             bit_ready;
  logic             accept;
  logic             out_free;

  assign bit_ready  = (state_q != ST_FULL);
  assign accept     = bus.i_bit_valid && bit_ready && !bus.i_clear;
  assign out_free   = !valid_q || bus.i_ready;
  assign shift_next = {shift_q[WIDTH-2:0], bus.i_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      shift_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Next state: clear discards the shift stage; the output handshake always proceeds.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q && !bus.i_ready;

    unique case (state_q)
      ST_COLLECT: begin
        if (bus.i_clear) begin
          shift_d = '0;
          cnt_d   = '0;
        end else if (accept) begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            if (out_free) begin
              word_d  = shift_next;
              valid_d = 1'b1;
              shift_d = '0;
              cnt_d   = '0;
            end else begin
              shift_d = shift_next;
              cnt_d   = CW'(WIDTH);
              state_d = ST_FULL;
            end
          end else begin
            shift_d = shift_next;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      ST_FULL: begin
        if (bus.i_clear) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_COLLECT;
        end else if (bus.i_ready) begin
          word_d  = shift_q;
          valid_d = 1'b1;
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  assign bus.o_bit_ready = bit_ready;
  assign bus.o_word      = word_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_count     = cnt_q;
endmodule

// File: tb/tb_shiftreg_deser.sv
// Scoreboard bench for shiftreg_deser (WIDTH=8): directed words plus a random-handshake soak.
module tb_shiftreg_deser;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;
  logic       rand_on;
  logic       hold_q;
  logic [7:0] held_word;
  logic [7:0] exp_q[$];
  int         hs_cyc[$];

  shiftreg_deser_if #(.WIDTH(WIDTH)) bus ();

  shiftreg_deser #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit and hold it until the DUT takes it.
  task automatic send_bit(input logic b);
    int guard;
    guard = 0;
    bus.i_bit       = b;
    bus.i_bit_valid = 1'b1;
    while (!bus.o_bit_ready && guard < 1000) begin
      tick();
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      errors++;
      $display("FAIL send_bit_timeout: o_bit_ready stuck at %0b, expected 1", bus.o_bit_ready);
    end
    tick();
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    bus.i_bit_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(bus.o_count), 32'd0);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_word"}, 32'(bus.o_word), 32'd0);
    check({tag, "_bit_ready"}, 32'(bus.o_bit_ready), 32'd1);
  endtask

  // Monitor: pop the scoreboard on every handshake and watch held-word stability.
  initial begin
    hold_q = 1'b0;
    held_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_q = 1'b0;
      end else begin
        if (hold_q && bus.o_valid)
          check("word_stable", 32'(bus.o_word), 32'(held_word));
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected no word", bus.o_word);
          end else begin
            check("word", 32'(bus.o_word), 32'(exp_q.pop_front()));
          end
          hs_cyc.push_back(cyc);
        end
        hold_q    = bus.o_valid && !bus.i_ready;
        held_word = bus.o_word;
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rand_on = 1'b0;
    bus.i_bit = 1'b0;
    bus.i_bit_valid = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_ready = 1'b1;
    rst = 1'b0;
    #1;
    do_reset();
    check_reset_state("reset");

    // Single word with consumer always ready: one-cycle o_valid pulse.
    exp_q.push_back(8'h9A);
    send_word(8'h9A);
    idle(0);
    check("t1_valid", 32'(bus.o_valid), 32'd1);
    check("t1_word", 32'(bus.o_word), 32'h9A);
    check("t1_count", 32'(bus.o_count), 32'd0);
    tick();
    check("t1_valid_fall", 32'(bus.o_valid), 32'd0);

    // Back-pressure: second word parks in FULL, extra bits are ignored.
    bus.i_ready = 1'b0;
    exp_q.push_back(8'h9A);
    exp_q.push_back(8'h3C);
    send_word(8'h9A);
    send_word(8'h3C);
    idle(0);
    bus.i_bit = 1'b1;
    bus.i_bit_valid = 1'b1;
    tick(); tick(); tick();
    bus.i_bit_valid = 1'b0;
    check("t2_word", 32'(bus.o_word), 32'h9A);
    check("t2_count", 32'(bus.o_count), 32'd8);
    check("t2_bit_ready", 32'(bus.o_bit_ready), 32'd0);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    check("t2_word2", 32'(bus.o_word), 32'h3C);
    check("t2_valid2", 32'(bus.o_valid), 32'd1);
    check("t2_bit_ready2", 32'(bus.o_bit_ready), 32'd1);
    check("t2_count2", 32'(bus.o_count), 32'd0);
    tick();
    bus.i_ready = 1'b1;
    idle(2);

    // Continuous stream: one word every 8 cycles.
    hs_cyc.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hFF);
    send_word(8'hA5);
    send_word(8'h0F);
    send_word(8'hFF);
    idle(3);
    check("t3_nwords", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      check("t3_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd8);
      check("t3_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd8);
    end

    // Clear mid-word, winning over a simultaneous valid bit.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus.i_clear = 1'b1;
    bus.i_bit = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    bus.i_bit_valid = 1'b0;
    check("t4_count_clr", 32'(bus.o_count), 32'd0);
    exp_q.push_back(8'h81);
    send_word(8'h81);
    idle(3);

    // Reset mid-word and in FULL discards everything.
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    idle(0);
    do_reset();
    check_reset_state("t5a");
    exp_q.push_back(8'h5A);
    send_word(8'h5A);
    idle(2);
    bus.i_ready = 1'b0;
    send_word(8'hC3);
    send_word(8'h7E);
    idle(1);
    check("t5_full_count", 32'(bus.o_count), 32'd8);
    do_reset();
    check_reset_state("t5b");
    bus.i_ready = 1'b1;
    exp_q.push_back(8'h66);
    send_word(8'h66);
    idle(3);

    // Soak: random bit gaps and random consumer readiness.
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          if (rand_on) bus.i_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int w = 0; w < 1000; w++) begin
      logic [7:0] word;
      word = 8'($urandom_range(0, 255));
      exp_q.push_back(word);
      for (int i = 7; i >= 0; i--) begin
        if ($urandom_range(0, 1) == 1) idle(1);
        send_bit(word[i]);
      end
    end
    bus.i_bit_valid = 1'b0;
    rand_on = 1'b0;
    tick();
    tick();
    bus.i_ready = 1'b1;
    begin
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
        tick();
        guard++;
      end
    end
    idle(2);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shiftreg_deser.md
SHIFTREG_DESER -- requirements
Module: shiftreg_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of bits per parallel word; legal range WIDTH >= 2.
REQ-002 The block SHALL have port clk  input  1  meaning the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port i_bit  input  1  meaning the serial data bit, MSB of each word first.
REQ-005 The block SHALL have port i_bit_valid  input  1  meaning i_bit is presented this cycle.
REQ-006 The block SHALL have port o_bit_ready  output  1  meaning the block can accept a serial bit this cycle.
REQ-007 The block SHALL have port i_clear  input  1  meaning discard the partially assembled word.
REQ-008 The block SHALL have port o_word  output  WIDTH  meaning the assembled parallel word.
REQ-009 The block SHALL have port o_valid  output  1  meaning o_word holds an unconsumed word.
REQ-010 The block SHALL have port i_ready  input  1  meaning the downstream consumer accepts o_word this cycle.
REQ-011 The block SHALL have port o_count  output  $clog2(WIDTH+1)  meaning the number of bits currently held in the shift stage (0..WIDTH).

Function
REQ-012 A bit SHALL be accepted at a rising edge iff i_bit_valid && o_bit_ready && !i_clear.
REQ-013 On acceptance, the shift stage SHALL shift left with i_bit entering bit 0, and o_count SHALL increment, so the first accepted bit of a word ends in o_word[WIDTH-1].
REQ-014 The output register SHALL be free this cycle iff !o_valid || i_ready.
REQ-015 When o_count becomes WIDTH on an accepting edge and the output register is free, the assembled word SHALL load into o_word at that same edge, o_valid SHALL be 1, and o_count SHALL return to 0.
REQ-016 Latency SHALL be zero extra cycles: o_valid rises in the cycle directly after the edge accepting the WIDTH-th bit.
REQ-017 If the output register is not free when the WIDTH-th bit is accepted, the shift stage SHALL hold the word (state FULL, o_count == WIDTH), and o_bit_ready SHALL be 0.
REQ-018 In state FULL, at the first edge with i_ready == 1, the held word SHALL move to o_word, o_valid SHALL remain 1, o_count SHALL become 0, and o_bit_ready SHALL be 1 in the following cycle.
REQ-019 o_bit_ready SHALL equal (o_count != WIDTH); it SHALL be combinational from state only and SHALL NOT depend on i_ready.
REQ-020 o_valid SHALL fall after an edge with o_valid && i_ready only when no new word loads at that edge.
REQ-021 o_word SHALL be stable while o_valid == 1 && i_ready == 0.
REQ-022 i_clear SHALL set o_count to 0 and discard the shift stage, including a FULL word not yet transferred, and i_clear SHALL win over a simultaneous accepted bit.
REQ-023 i_clear SHALL NOT affect o_word or o_valid, and the o_valid/i_ready handshake SHALL proceed normally in the same cycle.
REQ-024 Back-to-back words with i_bit_valid held at 1 and i_ready held at 1 SHALL stream with no gap cycles: one word every WIDTH cycles.
REQ-025 Inputs i_bit and i_bit_valid SHALL be ignored while o_bit_ready == 0, so no bit is lost or duplicated.

Reset
REQ-026 While rst == 1 at a rising edge, the block SHALL set o_count to 0, o_valid to 0, o_word to 0, and the shift stage to 0, and o_bit_ready SHALL be 1 in the next cycle.
REQ-027 rst SHALL take priority over i_clear, over bit acceptance, and over the handshake.
REQ-028 Reset asserted mid-word or in state FULL SHALL discard all held data, and no o_valid pulse SHALL follow.

Verification
REQ-029 WIDTH=8, i_ready=1, bits 1,0,0,1,1,0,1,0 on 8 consecutive cycles -> o_word=8'h9A with o_valid=1 for exactly one cycle after the 8th edge, and o_count=0.
REQ-030 i_ready=0, 16 bits forming 8'h9A then 8'h3C -> o_word=8'h9A held, o_count=8, o_bit_ready=0; then raise i_ready for one cycle -> o_word=8'h3C, o_valid=1, o_bit_ready=1.
REQ-031 Continuous stream with i_ready=1 -> words 8'hA5, 8'h0F, 8'hFF emitted exactly 8 cycles apart, with no dropped bits.
REQ-032 Send 5 bits, pulse i_clear together with a valid bit, then send 8 bits for 8'h81 -> o_word=8'h81 and no o_valid pulse for the partial word.
REQ-033 Assert rst after 3 bits and again in state FULL -> o_count=0, o_valid=0, o_word=0, o_bit_ready=1, and the next 8 bits produce the correct word.
REQ-034 Random i_bit_valid and random i_ready over 1000 words -> the output word sequence equals the input bit stream packed MSB-first, and o_word never changes while o_valid && !i_ready.
